// File: rtl/modsq_carry_resolve_if.sv
// Bus bundle between the modular squaring wrapper and the carry-resolve stage.
// The wrapper side uses master; the resolve stage uses slave.
interface modsq_carry_resolve_if #(
  parameter int NUM_ELEMENTS = 66,
  parameter int WORD_LEN     = 16
) ();
  localparam int IN_BITS  = NUM_ELEMENTS * WORD_LEN * 2;
  localparam int OUT_BITS = NUM_ELEMENTS * WORD_LEN;

  logic                in_valid;
  logic [IN_BITS-1:0]  sq_in;
  logic                busy;
  logic                out_valid;
  logic [OUT_BITS-1:0] result;
  logic                overflow;
  logic                overrun;

  modport master (
    output in_valid, sq_in,
    input  busy, out_valid, result, overflow, overrun
  );

  modport slave (
    input  in_valid, sq_in,
    output busy, out_valid, result, overflow, overrun
  );
endinterface

// File: rtl/modsq_carry_resolve.sv
// Serial carry resolution of the squarer's redundant coefficients, one
// coefficient per cycle LSB first, into a packed binary result plus overflow.
//
// state    | meaning
// ST_IDLE  | waiting for in_valid; result/overflow held
// ST_RUN   | adding coef[k] + carry, one word per edge
module modsq_carry_resolve #(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = 16,
  parameter int REDUNDANT_ELEMENTS = 2,
  parameter int BIT_LEN            = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  modsq_carry_resolve_if.slave sq_bus
);
  localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;
  localparam int SLOT_BITS    = 2 * WORD_LEN;
  localparam int IN_BITS      = NUM_ELEMENTS * SLOT_BITS;
  localparam int OUT_BITS     = NUM_ELEMENTS * WORD_LEN;
  localparam int SHADOW_BITS  = NUM_ELEMENTS * BIT_LEN;
  localparam int SPARE_BITS   = SLOT_BITS - BIT_LEN;
  localparam int SUM_BITS     = BIT_LEN + 2;
  localparam int K_BITS       = $clog2(NUM_ELEMENTS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(NUM_ELEMENTS - 1);

  logic [0:0]             state_q, state_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [1:0]             c_q, c_d;
  logic [SHADOW_BITS-1:0] shadow_q, shadow_d;
  logic [OUT_BITS-1:0]    wbuf_q, wbuf_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]    result_q, result_d;
  logic                   overflow_q, overflow_d;
  logic                   overrun_q, overrun_d;

  logic [SHADOW_BITS-1:0]             captured;
  logic [NUM_ELEMENTS*SPARE_BITS-1:0] unused_slot_bits;
  logic [SUM_BITS-1:0]                sum;
  logic [OUT_BITS-1:0]                wbuf_shifted;

  // Strip each 32-bit slot down to its 17 significant bits.
  always_comb begin
    captured         = '0;
    unused_slot_bits = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      captured[k*BIT_LEN +: BIT_LEN]            = sq_bus.sq_in[k*SLOT_BITS +: BIT_LEN];
      unused_slot_bits[k*SPARE_BITS +: SPARE_BITS] =
        sq_bus.sq_in[k*SLOT_BITS+BIT_LEN +: SPARE_BITS];
    end
  end

  // Shadow shifts right one coefficient per cycle, so coef[k] is always at the
  // bottom; the word buffer shifts in from the top so word 0 lands at bit 0
  // after the final step.
  assign sum          = SUM_BITS'(shadow_q[BIT_LEN-1:0]) + SUM_BITS'(c_q);
  assign wbuf_shifted = {sum[WORD_LEN-1:0], wbuf_q[OUT_BITS-1:WORD_LEN]};

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    shadow_d    = shadow_q;
    wbuf_d      = wbuf_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (sq_bus.in_valid) begin
          shadow_d = captured;
          k_d      = '0;
          c_d      = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sq_bus.in_valid) begin
          overrun_d = 1'b1;
        end
        shadow_d = shadow_q >> BIT_LEN;
        wbuf_d   = wbuf_shifted;
        c_d      = sum[WORD_LEN+1:WORD_LEN];
        k_d      = k_q + K_BITS'(1);
        if (k_q == K_LAST) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = wbuf_shifted;
          overflow_d  = |sum[SUM_BITS-1:WORD_LEN];
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      c_q         <= '0;
      shadow_q    <= '0;
      wbuf_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      shadow_q    <= shadow_d;
      wbuf_q      <= wbuf_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sq_bus.busy      = busy_q;
  assign sq_bus.out_valid = out_valid_q;
  assign sq_bus.result    = result_q;
  assign sq_bus.overflow  = overflow_q;
  assign sq_bus.overrun   = overrun_q;
endmodule

// File: tb/tb_modsq_carry_resolve.sv
// Directed bench for modsq_carry_resolve: expected results come from a
// big-integer sum model and are scoreboarded against out_valid pulses.
module tb_modsq_carry_resolve;
  localparam int NUM_ELEMENTS = 66;
  localparam int WORD_LEN     = 16;
  localparam int BIT_LEN      = 17;
  localparam int IN_BITS      = NUM_ELEMENTS * WORD_LEN * 2;
  localparam int OUT_BITS     = NUM_ELEMENTS * WORD_LEN;
  localparam int ACC_BITS     = OUT_BITS + 8;

  typedef struct {
    logic [OUT_BITS-1:0] res;
    logic                ovf;
    int unsigned         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int job_no = 0;
  exp_t sb[$];

  modsq_carry_resolve_if #(.NUM_ELEMENTS(NUM_ELEMENTS), .WORD_LEN(WORD_LEN)) sq_bus ();

  modsq_carry_resolve dut (
    .clk    (clk),
    .reset  (rst),
    .sq_bus (sq_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [IN_BITS-1:0] sq,
                                output logic [OUT_BITS-1:0] res, output logic ovf);
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] term;
    acc = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      term = '0;
      term[BIT_LEN-1:0] = sq[k*32 +: BIT_LEN];
      acc = acc + (term << (WORD_LEN * k));
    end
    res = acc[OUT_BITS-1:0];
    ovf = |acc[ACC_BITS-1:OUT_BITS];
  endfunction

  function automatic int first_diff(input logic [OUT_BITS-1:0] a, input logic [OUT_BITS-1:0] b);
    for (int k = 0; k < NUM_ELEMENTS; k++)
      if (a[k*WORD_LEN +: WORD_LEN] !== b[k*WORD_LEN +: WORD_LEN]) return k;
    return -1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkres(input string tag, input logic [OUT_BITS-1:0] obs, input logic [OUT_BITS-1:0] exp);
    int w;
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      w = first_diff(obs, exp);
      $error("FAIL %s word %0d observed %h expected %h", tag, w,
             obs[w*WORD_LEN +: WORD_LEN], exp[w*WORD_LEN +: WORD_LEN]);
    end
  endtask

  // Called just after a negedge; in_valid is seen by the next posedge.
  task automatic drive(input logic [IN_BITS-1:0] sq, input bit accept);
    exp_t e;
    sq_bus.in_valid = 1'b1;
    sq_bus.sq_in    = sq;
    if (accept) begin
      model(sq, e.res, e.ovf);
      e.cyc = cyc + NUM_ELEMENTS + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    sq_bus.in_valid = 1'b0;
    sq_bus.sq_in    = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sq_bus.busy === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_timeout", (n >= 400), 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sq_bus.out_valid === 1'b1) begin
      job_no++;
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious_out_valid observed pulse at cycle %0d expected none", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chkint($sformatf("job%0d_latency", job_no), int'(cyc), int'(e.cyc));
        chkres($sformatf("job%0d_result", job_no), sq_bus.result, e.res);
        chk1($sformatf("job%0d_overflow", job_no), sq_bus.overflow, e.ovf);
        chk1($sformatf("job%0d_busy_with_valid", job_no), sq_bus.busy, 1'b0);
      end
    end
  end

  initial begin
    logic [IN_BITS-1:0] sq;
    int n;

    rst = 1'b1;
    sq_bus.in_valid = 1'b0;
    sq_bus.sq_in    = '0;
    repeat (3) @(negedge clk);
    chk1("reset_busy", sq_bus.busy, 1'b0);
    chk1("reset_out_valid", sq_bus.out_valid, 1'b0);
    chk1("reset_overflow", sq_bus.overflow, 1'b0);
    chk1("reset_overrun", sq_bus.overrun, 1'b0);
    chkres("reset_result", sq_bus.result, '0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero input, busy duration
    sq = '0;
    drive(sq, 1'b1);
    n = 0;
    while (sq_bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chkint("zero_busy_cycles", n, NUM_ELEMENTS);
    wait_drain();
    chkres("zero_result_const", sq_bus.result, '0);

    // Single carry
    sq = '0;
    sq[16:0] = 17'h1FFFF;
    drive(sq, 1'b1);
    wait_drain();
    chk16("carry_word0", sq_bus.result[15:0], 16'hFFFF);
    chk16("carry_word1", sq_bus.result[31:16], 16'h0001);
    chk1("carry_overflow", sq_bus.overflow, 1'b0);

    // Full ripple
    sq = '0;
    sq[31:0] = 32'h0001_0000;
    for (int k = 1; k < NUM_ELEMENTS; k++) sq[k*32 +: 32] = 32'h0000_FFFF;
    drive(sq, 1'b1);
    wait_drain();
    chkres("ripple_result_const", sq_bus.result, '0);
    chk1("ripple_overflow", sq_bus.overflow, 1'b1);

    // Ignored slot bits, then back-to-back job in the out_valid cycle
    for (int k = 0; k < NUM_ELEMENTS; k++) sq[k*32 +: 32] = 32'hFFFE_0000 | 32'(k);
    drive(sq, 1'b1);
    n = 0;
    while (sq_bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("b2b_first_timeout", (n >= 200), 1'b0);
    chk16("slotbits_word65", sq_bus.result[65*16 +: 16], 16'd65);
    for (int k = 0; k < NUM_ELEMENTS; k++) sq[k*32 +: 32] = 32'hFFFE_0001;
    drive(sq, 1'b1);
    wait_drain();
    chk16("b2b_word0", sq_bus.result[15:0], 16'h0001);
    chk16("b2b_word65", sq_bus.result[65*16 +: 16], 16'h0001);

    // Overrun: second pulse ten cycles into the job is dropped
    sq = '0;
    sq[16:0] = 17'd5;
    drive(sq, 1'b1);
    repeat (9) @(negedge clk);
    chk1("overrun_before", sq_bus.overrun, 1'b0);
    sq[16:0] = 17'd7;
    drive(sq, 1'b0);
    chk1("overrun_set", sq_bus.overrun, 1'b1);
    wait_drain();
    chk16("overrun_word0", sq_bus.result[15:0], 16'd5);
    chk1("overrun_sticky", sq_bus.overrun, 1'b1);

    // Reset mid-job: job lost, outputs cleared at once
    sq = '0;
    sq[16:0] = 17'h0ABCD;
    drive(sq, 1'b0);
    repeat (28) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("midrst_busy", sq_bus.busy, 1'b0);
    chk1("midrst_out_valid", sq_bus.out_valid, 1'b0);
    chk1("midrst_overflow", sq_bus.overflow, 1'b0);
    chk1("midrst_overrun", sq_bus.overrun, 1'b0);
    chkres("midrst_result", sq_bus.result, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk1("midrst_idle_after", sq_bus.busy, 1'b0);
    sq = '0;
    sq[16:0] = 17'h12345;
    drive(sq, 1'b1);
    wait_drain();
    chk16("postrst_word0", sq_bus.result[15:0], 16'h2345);
    chk16("postrst_word1", sq_bus.result[31:16], 16'h0001);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
